icache_axi_read_bridge: RTL and testbench

//  Memory-side stage below the icache. Accepts one icache line-refill request and issues one AXI4 INCR read burst.

---
 rtl/icache_axi_read_bridge.sv | 137 +++++++++++++
 tb/tb_icache_axi_read_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_read_bridge.sv
// Refill bridge below the icache: turns one line request into one AXI4 INCR read burst
// and packs the returned beats into a full cache line.
module icache_axi_read_bridge #(
    parameter int unsigned PACKED_DATA_SIZE = 256,
    parameter int unsigned AXI_DATA_W       = 32,
    parameter int unsigned BEATS            = PACKED_DATA_SIZE / AXI_DATA_W,
    parameter logic [3:0]  AXI_ID           = 4'd0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        icache_mem_read_request,
    input  logic [31:0]                 icache_mem_read_addr,
    input  logic                        read_data_from_mem_ok,
    output logic                        mem_ready_to_read,
    output logic                        mem_read_addr_ok,
    output logic                        mem_return_en,
    output logic [PACKED_DATA_SIZE-1:0] mem_return_data,
    output logic                        mem_return_err,
    output logic [3:0]                  arid,
    output logic [31:0]                 araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [AXI_DATA_W-1:0]       rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready
);

    localparam int unsigned CntW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LineMask = PACKED_DATA_SIZE / 8 - 1;

    typedef enum logic [1:0] {StIdle, StAr, StRd, StRet} state_e;

    state_e                      state_q, state_d;
    logic [31:0]                 line_addr_q, line_addr_d;
    logic [PACKED_DATA_SIZE-1:0] data_q, data_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic                        addr_ok_q, addr_ok_d;
    logic                        last_cnt;

    assign last_cnt         = (cnt_q == CntW'(BEATS - 1));
    assign mem_return_data  = data_q;
    assign mem_read_addr_ok = addr_ok_q;

    always_comb begin
        state_d           = state_q;
        line_addr_d       = line_addr_q;
        data_d            = data_q;
        cnt_d             = cnt_q;
        err_d             = err_q;
        addr_ok_d         = 1'b0;
        mem_ready_to_read = 1'b0;
        mem_return_en     = 1'b0;
        mem_return_err    = 1'b0;
        arid              = 4'd0;
        araddr            = 32'd0;
        arlen             = 8'd0;
        arsize            = 3'd0;
        arburst           = 2'd0;
        arvalid           = 1'b0;
        rready            = 1'b0;

        unique case (state_q)
            StIdle: begin
                mem_ready_to_read = 1'b1;
                if (icache_mem_read_request) begin
                    line_addr_d = icache_mem_read_addr & ~32'(LineMask);
                    addr_ok_d   = 1'b1;
                    data_d      = '0;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    state_d     = StAr;
                end
            end
            StAr: begin
                arvalid = 1'b1;
                arid    = AXI_ID;
                araddr  = line_addr_q;
                arlen   = 8'(BEATS - 1);
                arsize  = 3'($clog2(AXI_DATA_W / 8));
                arburst = 2'b01;
                if (arready) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_d[int'(cnt_q)*AXI_DATA_W +: AXI_DATA_W] = rdata;
                    cnt_d = cnt_q + CntW'(1);
                    if (rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    // rlast disagreeing with the beat count (early or missing) is a burst error
                    if (rlast || last_cnt) begin
                        state_d = StRet;
                        if (rlast != last_cnt) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            StRet: begin
                mem_return_en  = 1'b1;
                mem_return_err = err_q;
                if (read_data_from_mem_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            line_addr_q <= 32'd0;
            data_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            addr_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            addr_ok_q   <= addr_ok_d;
        end
    end

endmodule

// File: tb/tb_icache_axi_read_bridge.sv
// Directed bench for icache_axi_read_bridge: drives and samples on the falling edge,
// hand-computed expected lines, latencies and AR-channel values.
module tb_icache_axi_read_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         icache_mem_read_request;
    logic [31:0]  icache_mem_read_addr;
    logic         read_data_from_mem_ok;
    logic         mem_ready_to_read;
    logic         mem_read_addr_ok;
    logic         mem_return_en;
    logic [255:0] mem_return_data;
    logic         mem_return_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int n_cmp = 0;
    int n_bad = 0;
    int ar_hs = 0;

    icache_axi_read_bridge dut (
        .clk                     (clk),
        .reset                   (reset),
        .icache_mem_read_request (icache_mem_read_request),
        .icache_mem_read_addr    (icache_mem_read_addr),
        .read_data_from_mem_ok   (read_data_from_mem_ok),
        .mem_ready_to_read       (mem_ready_to_read),
        .mem_read_addr_ok        (mem_read_addr_ok),
        .mem_return_en           (mem_return_en),
        .mem_return_data         (mem_return_data),
        .mem_return_err          (mem_return_err),
        .arid                    (arid),
        .araddr                  (araddr),
        .arlen                   (arlen),
        .arsize                  (arsize),
        .arburst                 (arburst),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .rdata                   (rdata),
        .rresp                   (rresp),
        .rlast                   (rlast),
        .rvalid                  (rvalid),
        .rready                  (rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arvalid && arready) ar_hs <= ar_hs + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_val(input int salt, input int k);
        return (32'(k + 1) * 32'h11) ^ (32'(salt) << 24);
    endfunction

    function automatic logic [255:0] exp_line(input int salt, input int n);
        logic [255:0] l = '0;
        for (int k = 0; k < n; k++) l[k*32 +: 32] = beat_val(salt, k);
        return l;
    endfunction

    // One request/burst; bad_beat gets rresp=SLVERR, rlast on last_beat (8 = never).
    task automatic burst(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input int ar_delay, input bit gaps, input int bad_beat,
                         input int last_beat, input int salt, output int lat);
        int k;
        bit slot;
        @(negedge clk);
        icache_mem_read_request = 1'b1;
        icache_mem_read_addr    = addr;
        lat = 0;
        @(negedge clk);
        lat++;
        icache_mem_read_request = 1'b0;
        chk("addr_ok_pulse", mem_read_addr_ok, 1'b1);
        chk("ready_low_ar", mem_ready_to_read, 1'b0);
        chk("arlen", arlen, 8'd7);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 4'd0);
        for (int d = 0; d <= ar_delay; d++) begin
            chk("arvalid_held", arvalid, 1'b1);
            chk("araddr_held", araddr, exp_addr);
            if (d < ar_delay) begin
                @(negedge clk);
                lat++;
            end
        end
        arready = 1'b1;
        @(negedge clk);
        lat++;
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 1'b0);
        chk("addr_ok_once", mem_read_addr_ok, 1'b0);
        chk("rready_rd", rready, 1'b1);
        k = 0;
        slot = 1'b0;
        while (lat < 60) begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            if (k < 8 && k <= last_beat && (!gaps || slot)) begin
                rvalid = 1'b1;
                rdata  = beat_val(salt, k);
                rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
                rlast  = (k == last_beat);
                k++;
            end
            slot = !slot;
            @(negedge clk);
            lat++;
            if (mem_return_en) break;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        if (lat >= 60) chk("return_timeout", 1'b0, 1'b1);
    endtask

    task automatic finish_ret(input logic [255:0] exp_data);
        read_data_from_mem_ok = 1'b1;
        @(negedge clk);
        read_data_from_mem_ok = 1'b0;
        chk("ret_done_en", mem_return_en, 1'b0);
        chk("ret_done_ready", mem_ready_to_read, 1'b1);
        chk("data_held_idle", mem_return_data, exp_data);
    endtask

    initial begin
        int lat;
        int hs0;
        reset = 1'b1;
        icache_mem_read_request = 1'b0;
        icache_mem_read_addr    = 32'd0;
        read_data_from_mem_ok   = 1'b0;
        arready = 1'b0;
        rdata   = 32'd0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", mem_ready_to_read, 1'b1);
        chk("rst_addr_ok", mem_read_addr_ok, 1'b0);
        chk("rst_en", mem_return_en, 1'b0);
        chk("rst_data", mem_return_data, 256'd0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        reset = 1'b0;

        // Test 1: back-to-back beats, minimum latency
        hs0 = ar_hs;
        burst(32'h8000_0004, 32'h8000_0000, 0, 1'b0, -1, 7, 0, lat);
        chk("t1_latency", lat, 10);
        chk("t1_data", mem_return_data,
            256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011);
        chk("t1_err", mem_return_err, 1'b0);
        chk("t1_one_hs", ar_hs - hs0, 1);
        // Hold in RET for 3 cycles with a competing request
        icache_mem_read_request = 1'b1;
        icache_mem_read_addr    = 32'h4000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ret_hold_en", mem_return_en, 1'b1);
            chk("ret_no_accept", mem_read_addr_ok, 1'b0);
            chk("ret_not_ready", mem_ready_to_read, 1'b0);
        end
        icache_mem_read_request = 1'b0;
        finish_ret(exp_line(0, 8));

        // Test 2: arready delayed 5 cycles
        hs0 = ar_hs;
        burst(32'h0000_1234, 32'h0000_1220, 5, 1'b0, -1, 7, 1, lat);
        chk("t2_latency", lat, 15);
        chk("t2_one_hs", ar_hs - hs0, 1);
        chk("t2_data", mem_return_data, exp_line(1, 8));
        chk("t2_err", mem_return_err, 1'b0);
        finish_ret(exp_line(1, 8));

        // Test 3: rvalid every other cycle
        burst(32'h1000_003F, 32'h1000_0020, 0, 1'b1, -1, 7, 2, lat);
        chk("t3_latency", lat, 18);
        chk("t3_data", mem_return_data, exp_line(2, 8));
        chk("t3_err", mem_return_err, 1'b0);
        finish_ret(exp_line(2, 8));

        // Test 4: SLVERR on beat 3 (index 2)
        burst(32'h2000_0040, 32'h2000_0040, 0, 1'b0, 2, 7, 3, lat);
        chk("t4_latency", lat, 10);
        chk("t4_data", mem_return_data, exp_line(3, 8));
        chk("t4_err", mem_return_err, 1'b1);
        finish_ret(exp_line(3, 8));

        // Test 5: early rlast on beat 4
        burst(32'h3000_0010, 32'h3000_0000, 0, 1'b0, -1, 3, 4, lat);
        chk("t5_latency", lat, 6);
        chk("t5_data", mem_return_data, exp_line(4, 4));
        chk("t5_err", mem_return_err, 1'b1);
        finish_ret(exp_line(4, 4));

        // Missing rlast on the final beat
        burst(32'h3000_0080, 32'h3000_0080, 0, 1'b0, -1, 8, 5, lat);
        chk("nolast_latency", lat, 10);
        chk("nolast_data", mem_return_data, exp_line(5, 8));
        chk("nolast_err", mem_return_err, 1'b1);
        finish_ret(exp_line(5, 8));

        // Test 6: reset in RD after 3 beats
        @(negedge clk);
        icache_mem_read_request = 1'b1;
        icache_mem_read_addr    = 32'hA000_0040;
        @(negedge clk);
        icache_mem_read_request = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1;
            rdata  = beat_val(6, k);
            @(negedge clk);
        end
        rvalid = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rready", rready, 1'b0);
        chk("t6_ready", mem_ready_to_read, 1'b1);
        chk("t6_arvalid", arvalid, 1'b0);
        chk("t6_en", mem_return_en, 1'b0);
        chk("t6_data_cleared", mem_return_data, 256'd0);
        burst(32'hA000_0044, 32'hA000_0040, 0, 1'b0, -1, 7, 7, lat);
        chk("t6_latency", lat, 10);
        chk("t6_data", mem_return_data, exp_line(7, 8));
        chk("t6_err", mem_return_err, 1'b0);
        finish_ret(exp_line(7, 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
